// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the fetch and decode stages: opcode encodings,
// instruction field positions and the bubble word placed in IF/ID.
package cpu_isa_pkg;

    localparam int ISA_INSTR_WIDTH = 16;
    localparam int OPCODE_MSB      = 15;
    localparam int OPCODE_LSB      = 12;
    localparam int OPCODE_WIDTH    = OPCODE_MSB - OPCODE_LSB + 1;

    localparam logic [OPCODE_WIDTH-1:0] OP_LOADI = 4'h0;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = 4'h1;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = 4'h2;
    localparam logic [OPCODE_WIDTH-1:0] OP_AND   = 4'h3;
    localparam logic [OPCODE_WIDTH-1:0] OP_OR    = 4'h4;
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR   = 4'h5;
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = 4'h6;
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE = 4'h7;
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 4'h8;
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = 4'h9;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP   = 4'hA;
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = 4'hF;

    // All-zero word: what IF/ID holds out of reset, decoded as a no-op.
    localparam logic [ISA_INSTR_WIDTH-1:0] BUBBLE_INSTR = '0;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction word (and its PC) that
// returns from memory while the IF/ID register is stalled.
module fetch_skid_buffer #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   load,
    input  logic                   drain,
    input  logic [INSTR_WIDTH-1:0] load_instr,
    input  logic [PC_WIDTH-1:0]    load_pc,
    output logic                   valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: PC sequencing, 1-cycle-latency instruction memory reads, stall
// buffering via a skid register, redirects, and HALT shutdown of fetching.
module instruction_fetch_unit
    import cpu_isa_pkg::*;
#(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = ISA_INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_en,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] ifid_instruction,
    output logic [3:0]             ifid_opcode,
    output logic [PC_WIDTH-1:0]    ifid_pc,
    output logic                   ifid_valid,
    output logic                   halted
);

    logic [PC_WIDTH-1:0]    pc_q;
    logic                   inflight_valid;
    logic [PC_WIDTH-1:0]    inflight_pc;
    logic                   skid_valid;
    logic [INSTR_WIDTH-1:0] skid_instr;
    logic [PC_WIDTH-1:0]    skid_pc;

    logic                   ret_halt;
    logic                   issue;
    logic                   advance;
    logic                   src_valid;
    logic [INSTR_WIDTH-1:0] src_instr;
    logic [PC_WIDTH-1:0]    src_pc;

    // A returning HALT blocks the next issue so nothing past it is fetched.
    assign ret_halt  = inflight_valid && (imem_rdata[OPCODE_MSB:OPCODE_LSB] == OP_HALT);
    assign issue     = rst_n && !halted && !redirect_valid && !stall && !skid_valid && !ret_halt;
    assign imem_en   = issue;
    assign imem_addr = pc_q;

    assign ifid_opcode = ifid_instruction[OPCODE_MSB:OPCODE_LSB];

    assign advance   = !halted && !redirect_valid && !stall;
    assign src_valid = skid_valid || inflight_valid;
    assign src_instr = skid_valid ? skid_instr : imem_rdata;
    assign src_pc    = skid_valid ? skid_pc : inflight_pc;

    fetch_skid_buffer #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (!halted && redirect_valid),
        .load       (!halted && !redirect_valid && stall && inflight_valid),
        .drain      (advance && skid_valid),
        .load_instr (imem_rdata),
        .load_pc    (inflight_pc),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q             <= RESET_PC;
            inflight_valid   <= 1'b0;
            inflight_pc      <= '0;
            ifid_instruction <= INSTR_WIDTH'(BUBBLE_INSTR);
            ifid_pc          <= '0;
            ifid_valid       <= 1'b0;
            halted           <= 1'b0;
        end else begin
            inflight_valid <= issue;
            if (issue) begin
                inflight_pc <= pc_q;
                pc_q        <= pc_q + PC_WIDTH'(1);
            end

            if (halted) begin
                ifid_valid <= 1'b0;
            end else if (redirect_valid) begin
                pc_q       <= redirect_pc;
                ifid_valid <= 1'b0;
            end else if (!stall) begin
                // With no source the instruction/pc are held and only valid drops.
                ifid_valid <= src_valid;
                if (src_valid) begin
                    ifid_instruction <= src_instr;
                    ifid_pc          <= src_pc;
                    if (src_instr[OPCODE_MSB:OPCODE_LSB] == OP_HALT) begin
                        halted <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector tables,
// hand-written HALT/reset/wrap sequences, and a random stream-level check.
module tb_instruction_fetch_unit;
    import cpu_isa_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = '0;
    logic [15:0] ifid_instruction;
    logic [3:0]  ifid_opcode;
    logic [7:0]  ifid_pc;
    logic        ifid_valid;
    logic        halted;

    logic        rst2_n = 1'b0;
    logic        imem2_en;
    logic [7:0]  imem2_addr;
    logic [15:0] imem2_rdata = '0;
    logic [15:0] ifid2_instruction;
    logic [3:0]  ifid2_opcode;
    logic [7:0]  ifid2_pc;
    logic        ifid2_valid;
    logic        halted2;

    logic [15:0] mem1 [256];
    logic [15:0] mem2 [256];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_en)  imem_rdata  <= mem1[imem_addr];
    always @(posedge clk) if (imem2_en) imem2_rdata <= mem2[imem2_addr];

    instruction_fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .ifid_instruction(ifid_instruction),
        .ifid_opcode(ifid_opcode), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
        .halted(halted)
    );

    instruction_fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'hFE)) dut2 (
        .clk(clk), .rst_n(rst2_n), .stall(1'b0), .redirect_valid(1'b0),
        .redirect_pc(8'h00), .imem_en(imem2_en), .imem_addr(imem2_addr),
        .imem_rdata(imem2_rdata), .ifid_instruction(ifid2_instruction),
        .ifid_opcode(ifid2_opcode), .ifid_pc(ifid2_pc), .ifid_valid(ifid2_valid),
        .halted(halted2)
    );

    typedef struct {
        logic       stall;
        logic       redir;
        logic [7:0] rpc;
        logic       en;
        logic       v;
        logic [7:0] pc;
        logic [3:0] op;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_directed_mem();
        for (int i = 0; i < 256; i++) mem1[i] = 16'h5000 | 16'(i);
        mem1[0] = 16'h1248;
        mem1[1] = 16'h2248;
        mem1[2] = 16'h3248;
        mem1[3] = 16'h4248;
    endtask

    initial begin
        logic [7:0]  exp_pc;
        logic [7:0]  exp_next;
        logic [7:0]  prev_tgt;
        logic        prev_stall;
        logic        prev_redir;
        logic        held_v;
        logic [7:0]  held_pc;
        logic [15:0] held_ins;
        int          idle;

        //            stall redir rpc    en  v   pc     op
        tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'h0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'h0};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 4'h1};
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 4'h2};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 4'h2};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 4'h2};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 4'h2};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 4'h3};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 4'h3};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 4'h4};
        tbl[10] = '{1'b1, 1'b1, 8'h20, 1'b0, 1'b1, 8'h04, 4'h5};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h04, 4'h5};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h04, 4'h5};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 4'h5};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h21, 4'h5};

        for (int i = 0; i < 256; i++) mem2[i] = 16'h1000 | 16'(i);

        // Reset, normal stream, 3-cycle stall, redirect with stall held high.
        load_directed_mem();
        do_reset();
        for (int k = 0; k < 15; k++) begin
            stall = tbl[k].stall;
            redirect_valid = tbl[k].redir;
            redirect_pc = tbl[k].rpc;
            #1;
            chk($sformatf("seqA[%0d].imem_en", k), 32'(imem_en), 32'(tbl[k].en));
            chk($sformatf("seqA[%0d].valid", k), 32'(ifid_valid), 32'(tbl[k].v));
            chk($sformatf("seqA[%0d].pc", k), 32'(ifid_pc), 32'(tbl[k].pc));
            chk($sformatf("seqA[%0d].opcode", k), 32'(ifid_opcode), 32'(tbl[k].op));
            chk($sformatf("seqA[%0d].halted", k), 32'(halted), 32'(0));
            @(negedge clk);
        end

        // HALT at address 3; later redirect/stall must be ignored.
        load_directed_mem();
        mem1[3] = 16'hF000;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            stall = (k == 7);
            redirect_valid = (k == 6);
            redirect_pc = 8'h10;
            #1;
            exp_pc = (k < 2) ? 8'h00 : (k <= 5) ? 8'(k - 2) : 8'h03;
            chk($sformatf("halt[%0d].imem_en", k), 32'(imem_en), 32'(k <= 3));
            chk($sformatf("halt[%0d].valid", k), 32'(ifid_valid), 32'(k >= 2 && k <= 5));
            chk($sformatf("halt[%0d].pc", k), 32'(ifid_pc), 32'(exp_pc));
            chk($sformatf("halt[%0d].opcode", k), 32'(ifid_opcode),
                (k < 2) ? 32'(0) : 32'(mem1[exp_pc][15:12]));
            chk($sformatf("halt[%0d].halted", k), 32'(halted), 32'(k >= 5));
            @(negedge clk);
        end
        stall = 1'b0;
        redirect_valid = 1'b0;

        // Asynchronous reset while stalled with the skid buffer full.
        load_directed_mem();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            stall = (k >= 3);
            @(negedge clk);
        end
        #3;
        rst_n = 1'b0;
        stall = 1'b0;
        #1;
        chk("arst.valid", 32'(ifid_valid), 32'(0));
        chk("arst.pc", 32'(ifid_pc), 32'(0));
        chk("arst.instruction", 32'(ifid_instruction), 32'(0));
        chk("arst.halted", 32'(halted), 32'(0));
        chk("arst.imem_en", 32'(imem_en), 32'(0));
        chk("arst.imem_addr", 32'(imem_addr), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("arst_rel[%0d].valid", k), 32'(ifid_valid), 32'(k >= 2));
            if (k >= 2) begin
                chk($sformatf("arst_rel[%0d].pc", k), 32'(ifid_pc), 32'(k - 2));
                chk($sformatf("arst_rel[%0d].instruction", k), 32'(ifid_instruction),
                    32'(mem1[k - 2]));
            end
            @(negedge clk);
        end

        // PC wrap from a non-zero reset PC.
        rst2_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_pc = 8'hFE + 8'(k - 2);
            chk($sformatf("wrap[%0d].valid", k), 32'(ifid2_valid), 32'(k >= 2));
            chk($sformatf("wrap[%0d].halted", k), 32'(halted2), 32'(0));
            if (k >= 2) begin
                chk($sformatf("wrap[%0d].pc", k), 32'(ifid2_pc), 32'(exp_pc));
                chk($sformatf("wrap[%0d].opcode", k), 32'(ifid2_opcode), 32'(mem2[exp_pc][15:12]));
            end
            @(negedge clk);
        end

        // Random stall/redirect traffic against a program-order stream model.
        for (int i = 0; i < 256; i++) mem1[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        do_reset();
        exp_next = 8'h00;
        prev_tgt = 8'h00;
        prev_stall = 1'b0;
        prev_redir = 1'b0;
        held_v = ifid_valid;
        held_pc = ifid_pc;
        held_ins = ifid_instruction;
        idle = 0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_redir) begin
                chk("rand.redirect_bubble", 32'(ifid_valid), 32'(0));
                exp_next = prev_tgt;
            end else if (prev_stall) begin
                chk("rand.stall_hold", {7'd0, ifid_valid, ifid_pc, ifid_instruction},
                    {7'd0, held_v, held_pc, held_ins});
            end else if (ifid_valid) begin
                chk("rand.stream_pc", 32'(ifid_pc), 32'(exp_next));
                chk("rand.stream_instr", 32'(ifid_instruction), 32'(mem1[exp_next]));
                exp_next = exp_next + 8'd1;
            end
            if (!ifid_valid && !prev_stall && !prev_redir) idle++;
            else idle = 0;
            chk("rand.starvation", 32'(idle > 2), 32'(0));
            held_v = ifid_valid;
            held_pc = ifid_pc;
            held_ins = ifid_instruction;

            stall = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc = 8'($urandom);
            #1;
            chk("rand.issue_blocked", 32'(imem_en && (stall || redirect_valid)), 32'(0));
            chk("rand.halted", 32'(halted), 32'(0));
            prev_stall = stall;
            prev_redir = redirect_valid;
            prev_tgt = redirect_pc;
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
